// File: rtl/vpu_top.sv
// Vector processing unit line path: boot sequencer loading the segment endpoints
// and a once-per-frame Cohen-Sutherland clipper feeding the frame-1 rasteriser.

module vpu_clipper #(
    parameter int REFRESH_MAX = 1666667,
    parameter int XMIN        = 0,
    parameter int XMAX        = 639,
    parameter int YMIN        = 0,
    parameter int YMAX        = 479
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_init_done,
    input  logic signed [15:0] i_lx0,
    input  logic signed [15:0] i_ly0,
    input  logic signed [15:0] i_lx1,
    input  logic signed [15:0] i_ly1,
    output logic signed [15:0] o_x0,
    output logic signed [15:0] o_y0,
    output logic signed [15:0] o_x1,
    output logic signed [15:0] o_y1
);
    localparam logic signed [15:0] C_XMIN = 16'(XMIN);
    localparam logic signed [15:0] C_XMAX = 16'(XMAX);
    localparam logic signed [15:0] C_YMIN = 16'(YMIN);
    localparam logic signed [15:0] C_YMAX = 16'(YMAX);

    typedef enum logic [1:0] {S_IDLE, S_CODE, S_DIV, S_DONE} state_t;

    // Outcode bit order {T,B,R,L}; bit 0 is tested first when picking an edge.
    function automatic logic [3:0] outcode(input logic signed [15:0] x, input logic signed [15:0] y);
        outcode = {(y > C_YMAX), (y < C_YMIN), (x > C_XMAX), (x < C_XMIN)};
    endfunction

    logic [20:0]        refresh_cnt;
    logic               w_tick;
    state_t             r_state, w_state_nxt;
    logic               w_load, w_setup, w_step, w_write, w_out;

    logic signed [15:0] r_px0, r_py0, r_px1, r_py1;
    logic signed [15:0] r_ox0, r_oy0, r_ox1, r_oy1;
    logic               r_sel, r_vert, r_neg;
    logic signed [15:0] r_edge, r_base;
    logic [33:0]        r_rem, r_dsr;
    logic [14:0]        r_quo;
    logic [4:0]         r_dcnt;
    logic [2:0]         r_pass;

    logic [3:0]         w_c0, w_c1, w_code;
    logic               w_pick1, w_vert;
    logic signed [15:0] w_edge, w_base;
    logic signed [16:0] w_fac, w_off, w_den;
    logic signed [31:0] w_prod;
    logic [31:0]        w_prod_mag;
    logic [16:0]        w_den_mag;
    logic               w_ge;
    logic [15:0]        w_q16;
    logic signed [15:0] w_res;

    assign w_tick = (refresh_cnt >= 21'(REFRESH_MAX));

    // Free-running frame counter; >= lets an overshooting value wrap on the next edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            refresh_cnt <= 21'd0;
        end else if (w_tick) begin
            refresh_cnt <= 21'd0;
        end else begin
            refresh_cnt <= refresh_cnt + 21'd1;
        end
    end

    assign w_c0    = outcode(r_px0, r_py0);
    assign w_c1    = outcode(r_px1, r_py1);
    assign w_pick1 = (w_c0 == 4'd0);
    assign w_code  = w_pick1 ? w_c1 : w_c0;
    assign w_vert  = w_code[0] | w_code[1];

    // Boundary selection and the signed product/divisor for one clip step, based on P0.
    always_comb begin
        w_edge = C_YMAX;
        if (w_code[0]) begin
            w_edge = C_XMIN;
        end else if (w_code[1]) begin
            w_edge = C_XMAX;
        end else if (w_code[2]) begin
            w_edge = C_YMIN;
        end else begin
            w_edge = C_YMAX;
        end
        if (w_vert) begin
            w_fac  = {r_py1[15], r_py1} - {r_py0[15], r_py0};
            w_off  = {w_edge[15], w_edge} - {r_px0[15], r_px0};
            w_den  = {r_px1[15], r_px1} - {r_px0[15], r_px0};
            w_base = r_py0;
        end else begin
            w_fac  = {r_px1[15], r_px1} - {r_px0[15], r_px0};
            w_off  = {w_edge[15], w_edge} - {r_py0[15], r_py0};
            w_den  = {r_py1[15], r_py1} - {r_py0[15], r_py0};
            w_base = r_px0;
        end
        w_prod = $signed({{15{w_fac[16]}}, w_fac}) * $signed({{15{w_off[16]}}, w_off});
        if (w_prod[31]) begin
            w_prod_mag = 32'd0 - w_prod;
        end else begin
            w_prod_mag = w_prod;
        end
        if (w_den[16]) begin
            w_den_mag = 17'd0 - w_den;
        end else begin
            w_den_mag = w_den;
        end
    end

    // Restoring division step; the quotient is kept mod 2^16 since the result is 16-bit.
    assign w_ge  = (r_rem >= r_dsr);
    assign w_q16 = {r_quo, w_ge};
    assign w_res = r_neg ? (r_base - $signed(w_q16)) : (r_base + $signed(w_q16));

    // Clipper state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_setup     = 1'b0;
        w_step      = 1'b0;
        w_write     = 1'b0;
        w_out       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick && i_init_done) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CODE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CODE: begin
                if ((w_c0 == 4'd0) && (w_c1 == 4'd0)) begin
                    w_state_nxt = S_DONE;
                end else if ((w_c0 & w_c1) != 4'd0) begin
                    w_state_nxt = S_IDLE;
                end else if (r_pass == 3'd4) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_setup     = 1'b1;
                    w_state_nxt = S_DIV;
                end
            end
            S_DIV: begin
                w_step = 1'b1;
                if (r_dcnt == 5'd16) begin
                    w_write     = 1'b1;
                    w_state_nxt = S_CODE;
                end else begin
                    w_state_nxt = S_DIV;
                end
            end
            S_DONE: begin
                w_out       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Working endpoints and divider registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_px0 <= 16'sd0; r_py0 <= 16'sd0; r_px1 <= 16'sd0; r_py1 <= 16'sd0;
            r_sel <= 1'b0; r_vert <= 1'b0; r_neg <= 1'b0;
            r_edge <= 16'sd0; r_base <= 16'sd0;
            r_rem <= 34'd0; r_dsr <= 34'd0; r_quo <= 15'd0;
            r_dcnt <= 5'd0; r_pass <= 3'd0;
        end else begin
            if (w_load) begin
                r_px0  <= i_lx0; r_py0 <= i_ly0; r_px1 <= i_lx1; r_py1 <= i_ly1;
                r_pass <= 3'd0;
            end
            if (w_setup) begin
                r_sel  <= w_pick1;
                r_vert <= w_vert;
                r_edge <= w_edge;
                r_base <= w_base;
                r_neg  <= w_prod[31] ^ w_den[16];
                r_rem  <= {2'b00, w_prod_mag};
                r_dsr  <= {1'b0, w_den_mag, 16'd0};
                r_quo  <= 15'd0;
                r_dcnt <= 5'd0;
                r_pass <= r_pass + 3'd1;
            end
            if (w_step) begin
                r_rem  <= w_ge ? (r_rem - r_dsr) : r_rem;
                r_dsr  <= {1'b0, r_dsr[33:1]};
                r_quo  <= w_q16[14:0];
                r_dcnt <= r_dcnt + 5'd1;
            end
            if (w_write) begin
                case ({r_sel, r_vert})
                    2'b01:   begin r_px0 <= r_edge; r_py0 <= w_res; end
                    2'b00:   begin r_px0 <= w_res;  r_py0 <= r_edge; end
                    2'b11:   begin r_px1 <= r_edge; r_py1 <= w_res; end
                    default: begin r_px1 <= w_res;  r_py1 <= r_edge; end
                endcase
            end
        end
    end

    // Output registers, updated only when a segment is accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ox0 <= 16'sd0; r_oy0 <= 16'sd0; r_ox1 <= 16'sd0; r_oy1 <= 16'sd0;
        end else if (w_out) begin
            r_ox0 <= r_px0; r_oy0 <= r_py0; r_ox1 <= r_px1; r_oy1 <= r_py1;
        end
    end

    assign o_x0 = r_ox0;
    assign o_y0 = r_oy0;
    assign o_x1 = r_ox1;
    assign o_y1 = r_oy1;
endmodule

module vpu_top #(
    parameter int REFRESH_MAX = 1666667,
    parameter int INIT_LAST   = 11,
    parameter int XMIN        = 0,
    parameter int XMAX        = 639,
    parameter int YMIN        = 0,
    parameter int YMAX        = 479,
    parameter int LX0         = -100,
    parameter int LY0         = 100,
    parameter int LX1         = 700,
    parameter int LY1         = 500
) (
    input  logic               clkin,
    input  logic               rst_n,
    output logic signed [15:0] x0_in_f1,
    output logic signed [15:0] y0_in_f1,
    output logic signed [15:0] x1_in_f1,
    output logic signed [15:0] y1_in_f1
);
    logic [3:0]         cnt;
    logic signed [15:0] r_lx0, r_ly0, r_lx1, r_ly1;
    logic               w_init_done;

    assign w_init_done = (cnt == 4'(INIT_LAST));

    // Boot counter, saturating at its last value.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (!w_init_done) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Endpoint registers loaded one per boot cycle.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_lx0 <= 16'sd0; r_ly0 <= 16'sd0; r_lx1 <= 16'sd0; r_ly1 <= 16'sd0;
        end else begin
            case (cnt)
                4'd0:    r_lx0 <= 16'(LX0);
                4'd1:    r_ly0 <= 16'(LY0);
                4'd2:    r_lx1 <= 16'(LX1);
                4'd3:    r_ly1 <= 16'(LY1);
                default: r_lx0 <= r_lx0;
            endcase
        end
    end

    vpu_clipper #(
        .REFRESH_MAX (REFRESH_MAX),
        .XMIN        (XMIN),
        .XMAX        (XMAX),
        .YMIN        (YMIN),
        .YMAX        (YMAX)
    ) clipper (
        .i_clk       (clkin),
        .i_rst_n     (rst_n),
        .i_init_done (w_init_done),
        .i_lx0       (r_lx0),
        .i_ly0       (r_ly0),
        .i_lx1       (r_lx1),
        .i_ly1       (r_ly1),
        .o_x0        (x0_in_f1),
        .o_y0        (y0_in_f1),
        .o_x1        (x1_in_f1),
        .o_y1        (y1_in_f1)
    );
endmodule

// File: tb/tb_vpu_top.sv
// Scoreboard bench for vpu_top: default segment, a trivially accepted segment and
// a trivially rejected segment run side by side on a shared clock and reset.

module tb_vpu_top;
    logic clk;
    logic rst_n;
    logic signed [15:0] a_x0, a_y0, a_x1, a_y1;
    logic signed [15:0] b_x0, b_y0, b_x1, b_y1;
    logic signed [15:0] c_x0, c_y0, c_x1, c_y1;

    int n_tests;
    int n_fail;
    logic [63:0] exp_q[$];

    vpu_top dut (
        .clkin(clk), .rst_n(rst_n),
        .x0_in_f1(a_x0), .y0_in_f1(a_y0), .x1_in_f1(a_x1), .y1_in_f1(a_y1)
    );
    vpu_top #(.LX0(10), .LY0(20), .LX1(300), .LY1(400)) dut_acc (
        .clkin(clk), .rst_n(rst_n),
        .x0_in_f1(b_x0), .y0_in_f1(b_y0), .x1_in_f1(b_x1), .y1_in_f1(b_y1)
    );
    vpu_top #(.LX0(-50), .LY0(-5), .LX1(-10), .LY1(-1)) dut_rej (
        .clkin(clk), .rst_n(rst_n),
        .x0_in_f1(c_x0), .y0_in_f1(c_y0), .x1_in_f1(c_x1), .y1_in_f1(c_y1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int x0, input int y0, input int x1, input int y1);
        pk = {16'(x0), 16'(y0), 16'(x1), 16'(y1)};
    endfunction

    function automatic logic [63:0] out_a();
        out_a = {a_x0, a_y0, a_x1, a_y1};
    endfunction
    function automatic logic [63:0] out_b();
        out_b = {b_x0, b_y0, b_x1, b_y1};
    endfunction
    function automatic logic [63:0] out_c();
        out_c = {c_x0, c_y0, c_x1, c_y1};
    endfunction

    // Called at a negedge; returns #1 after the edge on which the tick fires.
    task automatic force_tick_all();
        force dut.clipper.refresh_cnt     = 21'd1666667;
        force dut_acc.clipper.refresh_cnt = 21'd1666667;
        force dut_rej.clipper.refresh_cnt = 21'd1666667;
        @(posedge clk);
        #1;
        release dut.clipper.refresh_cnt;
        release dut_acc.clipper.refresh_cnt;
        release dut_rej.clipper.refresh_cnt;
    endtask

    // Bounded wait for the default DUT's outputs to reach a non-reset value.
    task automatic wait_a_output(input string tag);
        int k;
        k = 0;
        while ((out_a() == 64'd0) && (k < 200)) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq({tag, "_timeout"}, 64'(k < 200), 64'd1);
    endtask

    initial begin
        logic [63:0] e;
        n_tests = 0;
        n_fail  = 0;

        // Reset with frame counters held at zero.
        rst_n = 1'b0;
        force dut.clipper.refresh_cnt     = 21'd0;
        force dut_acc.clipper.refresh_cnt = 21'd0;
        force dut_rej.clipper.refresh_cnt = 21'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out", out_a(), 64'd0);
        check_eq("rst_cnt", 64'(dut.cnt), 64'd0);
        @(negedge clk);
        release dut.clipper.refresh_cnt;
        release dut_acc.clipper.refresh_cnt;
        release dut_rej.clipper.refresh_cnt;
        rst_n = 1'b1;

        // Boot; an early tick at cnt==5 must be dropped.
        repeat (5) @(posedge clk);
        #1;
        check_eq("cnt5", 64'(dut.cnt), 64'd5);
        @(negedge clk);
        force_tick_all();
        repeat (4) @(posedge clk);
        #1;
        check_eq("cnt10", 64'(dut.cnt), 64'd10);
        @(posedge clk);
        #1;
        check_eq("cnt11", 64'(dut.cnt), 64'd11);
        repeat (30) @(posedge clk);
        #1;
        check_eq("cnt_hold", 64'(dut.cnt), 64'd11);
        check_eq("early_tick_a", out_a(), 64'd0);
        check_eq("early_tick_b", out_b(), 64'd0);

        // First accepted frame on all three instances.
        exp_q.push_back(pk(0, 150, 639, 469));
        exp_q.push_back(pk(0, 0, 0, 0));
        @(negedge clk);
        force_tick_all();
        check_eq("acc_lat0", out_b(), 64'd0);
        @(posedge clk);
        #1;
        check_eq("acc_lat1", out_b(), 64'd0);
        @(posedge clk);
        #1;
        check_eq("acc_lat2", out_b(), pk(10, 20, 300, 400));
        wait_a_output("clip");
        e = exp_q.pop_front();
        check_eq("clip_a", out_a(), e);
        e = exp_q.pop_front();
        check_eq("reject_c", out_c(), e);
        repeat (50) @(posedge clk);
        #1;
        check_eq("clip_a_stable", out_a(), pk(0, 150, 639, 469));
        check_eq("acc_b_stable", out_b(), pk(10, 20, 300, 400));

        // Reset in the middle of the first divide pass.
        @(negedge clk);
        force_tick_all();
        repeat (8) @(posedge clk);
        #1;
        check_eq("div_hold_a", out_a(), pk(0, 150, 639, 469));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_a", out_a(), 64'd0);
        check_eq("midrst_b", out_b(), 64'd0);
        check_eq("midrst_cnt", 64'(dut.cnt), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check_eq("reboot_cnt", 64'(dut.cnt), 64'd11);
        check_eq("reboot_out", out_a(), 64'd0);
        exp_q.push_back(pk(0, 150, 639, 469));
        @(negedge clk);
        force_tick_all();
        wait_a_output("reclip");
        e = exp_q.pop_front();
        check_eq("reclip_a", out_a(), e);
        check_eq("reclip_c", out_c(), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
